// File: rtl/lcd_hd44780_if.sv
// HD44780 2x16 character LCD driver over the 4-bit bus.
// Keeps a 32-byte shadow of the display that lcd_control writes into at any time.
// Runs the power-up init sequence on its own and repaints the whole panel on request.
module lcd_hd44780_if #(
    parameter int T_PWRUP = 750000,
    parameter int T_INIT1 = 205000,
    parameter int T_INIT2 = 5000,
    parameter int T_E     = 12,
    parameter int T_CMD   = 2000,
    parameter int T_CLR   = 82000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       lcd_row,
    input  logic [3:0] lcd_col,
    input  logic [7:0] lcd_char,
    input  logic       lcd_we,
    input  logic       update,
    output logic       lcd_busy,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [3:0] LCD_DB
);

    typedef enum logic [1:0] {PWRUP, INIT, IDLE, REFRESH} state_t;
    typedef enum logic [2:0] {LOAD, SETUP, EHIGH, ELOW, WAIT} phase_t;

    // Counter reload values; the counter runs down to zero inclusive.
    localparam logic [19:0] C_PWRUP = 20'(T_PWRUP - 1);
    localparam logic [19:0] C_INIT1 = 20'(T_INIT1 - 1);
    localparam logic [19:0] C_INIT2 = 20'(T_INIT2 - 1);
    localparam logic [19:0] C_E     = 20'(T_E - 1);
    localparam logic [19:0] C_CMD   = 20'(T_CMD - 1);
    localparam logic [19:0] C_CLR   = 20'(T_CLR - 1);

    state_t      state;
    phase_t      phase;
    logic [19:0] cnt;
    logic [5:0]  idx;
    logic        half;
    logic [3:0]  low_nib;
    logic        pending;
    logic [7:0]  char_buf [32];

    logic [7:0]  step_byte;
    logic        step_rs;
    logic        step_single;
    logic [19:0] step_wait;
    logic        last_step;
    logic [4:0]  buf_addr;

    assign LCD_RW = 1'b0;

    // Shadow buffer: lcd_control writes land every cycle regardless of the bus activity.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 32; i++) char_buf[i] <= 8'h20;
        end else if (lcd_we) begin
            char_buf[{lcd_row, lcd_col}] <= lcd_char;
        end
    end

    // Decode the current step index into the byte to send, its RS, and its post-wait.
    always_comb begin
        step_byte   = 8'h00;
        step_rs     = 1'b0;
        step_single = 1'b0;
        step_wait   = C_CMD;
        last_step   = 1'b0;
        buf_addr    = 5'd0;
        if (state == INIT) begin
            case (idx)
                6'd0: begin step_byte = 8'h30; step_single = 1'b1; step_wait = C_INIT1; end
                6'd1: begin step_byte = 8'h30; step_single = 1'b1; step_wait = C_INIT2; end
                6'd2: begin step_byte = 8'h30; step_single = 1'b1; end
                6'd3: begin step_byte = 8'h20; step_single = 1'b1; end
                6'd4: step_byte = 8'h28;
                6'd5: step_byte = 8'h0C;
                6'd6: step_byte = 8'h06;
                default: begin step_byte = 8'h01; step_wait = C_CLR; last_step = 1'b1; end
            endcase
        end else begin
            if (idx == 6'd0) begin
                step_byte = 8'h80;
            end else if (idx == 6'd17) begin
                step_byte = 8'hC0;
            end else begin
                step_rs   = 1'b1;
                buf_addr  = (idx <= 6'd16) ? 5'(idx - 6'd1) : 5'(idx - 6'd2);
                step_byte = char_buf[buf_addr];
            end
            last_step = (idx == 6'd33);
        end
    end

    // Sequencer: power-up wait, init steps, idle and refresh, each byte split into E-strobed nibbles.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= PWRUP;
            phase    <= LOAD;
            cnt      <= C_PWRUP;
            idx      <= 6'd0;
            half     <= 1'b0;
            low_nib  <= 4'h0;
            pending  <= 1'b0;
            lcd_busy <= 1'b1;
            LCD_E    <= 1'b0;
            LCD_RS   <= 1'b0;
            LCD_DB   <= 4'h0;
        end else begin
            if (update && state != IDLE) pending <= 1'b1;
            case (state)
                PWRUP: begin
                    if (cnt == 20'd0) begin
                        state <= INIT;
                        phase <= LOAD;
                        idx   <= 6'd0;
                    end else begin
                        cnt <= cnt - 20'd1;
                    end
                end
                IDLE: begin
                    LCD_E <= 1'b0;
                    if (update || pending) begin
                        pending  <= 1'b0;
                        state    <= REFRESH;
                        phase    <= LOAD;
                        idx      <= 6'd0;
                        lcd_busy <= 1'b1;
                    end
                end
                default: begin
                    case (phase)
                        LOAD: begin
                            low_nib <= step_byte[3:0];
                            LCD_DB  <= step_byte[7:4];
                            LCD_RS  <= step_rs;
                            half    <= 1'b0;
                            phase   <= SETUP;
                        end
                        SETUP: begin
                            LCD_E <= 1'b1;
                            cnt   <= C_E;
                            phase <= EHIGH;
                        end
                        EHIGH: begin
                            if (cnt == 20'd0) begin
                                LCD_E <= 1'b0;
                                cnt   <= C_E;
                                phase <= ELOW;
                            end else begin
                                cnt <= cnt - 20'd1;
                            end
                        end
                        ELOW: begin
                            if (cnt != 20'd0) begin
                                cnt <= cnt - 20'd1;
                            end else if (!half && !step_single) begin
                                half   <= 1'b1;
                                LCD_DB <= low_nib;
                                phase  <= SETUP;
                            end else begin
                                cnt   <= step_wait;
                                phase <= WAIT;
                            end
                        end
                        WAIT: begin
                            if (cnt != 20'd0) begin
                                cnt <= cnt - 20'd1;
                            end else if (last_step) begin
                                state    <= IDLE;
                                lcd_busy <= 1'b0;
                                idx      <= 6'd0;
                            end else begin
                                idx   <= idx + 6'd1;
                                phase <= LOAD;
                            end
                        end
                        default: phase <= LOAD;
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_hd44780_if.sv
// Testbench for lcd_hd44780_if with shortened timing parameters.
// A bus monitor decodes every E pulse and checks its timing; a shadow-buffer model predicts refresh contents.
module tb_lcd_hd44780_if;

    localparam int T_PWRUP = 10;
    localparam int T_INIT1 = 8;
    localparam int T_INIT2 = 6;
    localparam int T_E     = 2;
    localparam int T_CMD   = 4;
    localparam int T_CLR   = 9;

    localparam logic [3:0] INIT_NIBS [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8,
                                              4'h0, 4'hC, 4'h0, 4'h6, 4'h0, 4'h1};

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       lcd_row = 1'b0;
    logic [3:0] lcd_col = 4'h0;
    logic [7:0] lcd_char = 8'h00;
    logic       lcd_we = 1'b0;
    logic       update = 1'b0;
    logic       lcd_busy, LCD_E, LCD_RS, LCD_RW;
    logic [3:0] LCD_DB;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_fall_cyc = 0;
    int busy_fall_cyc = 0;

    logic [7:0] model [32];
    logic [4:0] cap [$];

    logic       prev_e = 1'b0, prev_rs = 1'b0, prev_busy = 1'b1;
    logic [3:0] prev_db = 4'h0;
    logic [3:0] nib_db = 4'h0;
    logic       nib_rs = 1'b0;
    int         high_cnt = 0;

    typedef struct {
        logic       we;
        logic       row;
        logic [3:0] col;
        logic [7:0] ch;
        int         pos;
        logic [7:0] exp_byte;
    } vec_t;

    lcd_hd44780_if #(
        .T_PWRUP(T_PWRUP), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2),
        .T_E(T_E), .T_CMD(T_CMD), .T_CLR(T_CLR)
    ) dut (
        .CLK(CLK), .RST(RST), .lcd_row(lcd_row), .lcd_col(lcd_col), .lcd_char(lcd_char),
        .lcd_we(lcd_we), .update(update), .lcd_busy(lcd_busy), .LCD_E(LCD_E),
        .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_DB(LCD_DB)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bus monitor: decodes nibbles and checks setup, E high time and hold around every pulse.
    always @(negedge CLK) begin
        cyc++;
        if (!RST) begin
            prev_e = 1'b0; prev_rs = 1'b0; prev_db = 4'h0; prev_busy = 1'b1; high_cnt = 0;
        end else begin
            if (LCD_E && !prev_e) begin
                checkOutput("setup DB", LCD_DB, prev_db);
                checkOutput("setup RS", LCD_RS, prev_rs);
                nib_db = LCD_DB; nib_rs = LCD_RS; high_cnt = 1;
            end else if (LCD_E) begin
                high_cnt++;
                checkOutput("hold DB", LCD_DB, nib_db);
                checkOutput("hold RS", LCD_RS, nib_rs);
            end else if (prev_e) begin
                checkOutput("E high time", high_cnt, T_E);
                checkOutput("post-fall DB", LCD_DB, nib_db);
                checkOutput("post-fall RS", LCD_RS, nib_rs);
                cap.push_back({nib_rs, nib_db});
                last_fall_cyc = cyc;
            end
            if (!lcd_busy && prev_busy) busy_fall_cyc = cyc;
            prev_e = LCD_E; prev_db = LCD_DB; prev_rs = LCD_RS; prev_busy = lcd_busy;
        end
    end

    task automatic tick();
        @(negedge CLK);
        #2;
    endtask

    task automatic resetModel();
        for (int i = 0; i < 32; i++) model[i] = 8'h20;
    endtask

    task automatic applyStimulus(input logic we, input logic row, input logic [3:0] col,
                                 input logic [7:0] ch, input logic upd);
        tick();
        lcd_we = we; lcd_row = row; lcd_col = col; lcd_char = ch; update = upd;
        if (we) model[{row, col}] = ch;
        tick();
        lcd_we = 1'b0; update = 1'b0;
    endtask

    task automatic waitQuiet(input string name, input int budget);
        int n = 0;
        int quiet = 0;
        while (quiet < 3 && n < budget) begin
            @(negedge CLK);
            n++;
            quiet = lcd_busy ? 0 : quiet + 1;
        end
        checkOutput({name, " reached idle"}, (quiet >= 3) ? 1 : 0, 1);
    endtask

    task automatic checkInit(input string name);
        logic [4:0] n;
        for (int i = 0; i < 12; i++) begin
            if (cap.size() == 0) break;
            n = cap.pop_front();
            checkOutput($sformatf("%s nibble %0d", name, i), n, {1'b0, INIT_NIBS[i]});
        end
    endtask

    function automatic int unsigned byteAt(input int p);
        if (2 * p + 1 < cap.size()) return {24'h0, cap[2*p][3:0], cap[2*p+1][3:0]};
        return 32'hFFFF;
    endfunction

    task automatic checkRefresh(input string name);
        logic [7:0] eb [34];
        logic       ers [34];
        eb[0] = 8'h80; ers[0] = 1'b0;
        eb[17] = 8'hC0; ers[17] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            eb[1+i]  = model[i];    ers[1+i]  = 1'b1;
            eb[18+i] = model[16+i]; ers[18+i] = 1'b1;
        end
        checkOutput({name, " nibble count"}, cap.size(), 68);
        for (int i = 0; i < 34 && 2 * i + 1 < cap.size(); i++) begin
            checkOutput($sformatf("%s byte %0d", name, i), byteAt(i), eb[i]);
            checkOutput($sformatf("%s RS hi %0d", name, i), cap[2*i][4], ers[i]);
            checkOutput($sformatf("%s RS lo %0d", name, i), cap[2*i+1][4], ers[i]);
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs [7];
        int n;
        int sz;

        vecs[0] = '{1'b1, 1'b0, 4'd0,  8'h48, 1,  8'h48};
        vecs[1] = '{1'b1, 1'b0, 4'd1,  8'h45, 2,  8'h45};
        vecs[2] = '{1'b1, 1'b0, 4'd2,  8'h4C, 3,  8'h4C};
        vecs[3] = '{1'b1, 1'b0, 4'd3,  8'h4C, 4,  8'h4C};
        vecs[4] = '{1'b1, 1'b0, 4'd4,  8'h4F, 5,  8'h4F};
        vecs[5] = '{1'b0, 1'b0, 4'd5,  8'h00, 6,  8'h20};
        vecs[6] = '{1'b1, 1'b1, 4'd15, 8'h41, 33, 8'h41};

        // Reset values, then the power-up init sequence with no stimulus.
        resetModel();
        repeat (3) @(negedge CLK);
        checkOutput("reset E", LCD_E, 0);
        checkOutput("reset RS", LCD_RS, 0);
        checkOutput("reset RW", LCD_RW, 0);
        checkOutput("reset DB", LCD_DB, 0);
        checkOutput("reset busy", lcd_busy, 1);
        #2 RST = 1'b1;
        waitQuiet("init", 2000);
        checkOutput("init pulse count", cap.size(), 12);
        checkOutput("busy fall after clear wait", busy_fall_cyc - last_fall_cyc, T_E + T_CLR);
        checkInit("init");

        // Single update pulse refreshes the blank buffer.
        cap.delete();
        checkOutput("busy low in idle", lcd_busy, 0);
        tick();
        update = 1'b1;
        @(negedge CLK);
        checkOutput("busy rises after update", lcd_busy, 1);
        #2 update = 1'b0;
        waitQuiet("blank refresh", 2000);
        checkRefresh("blank refresh");

        // Table-driven writes, then refresh and spot-check positions.
        for (int i = 0; i < 7; i++)
            if (vecs[i].we) applyStimulus(1'b1, vecs[i].row, vecs[i].col, vecs[i].ch, 1'b0);
        cap.delete();
        applyStimulus(1'b0, 1'b0, 4'h0, 8'h00, 1'b1);
        waitQuiet("hello refresh", 2000);
        for (int i = 0; i < 7; i++)
            checkOutput($sformatf("table pos %0d", vecs[i].pos), byteAt(vecs[i].pos), vecs[i].exp_byte);
        checkRefresh("hello refresh");

        // Updates during init merge into exactly one refresh.
        tick();
        RST = 1'b0;
        resetModel();
        repeat (3) tick();
        cap.delete();
        RST = 1'b1;
        for (int c = 0; c < 70; c++) begin
            tick();
            update = (c == 5 || c == 30 || c == 60);
        end
        update = 1'b0;
        waitQuiet("merged updates", 3000);
        checkOutput("merged total pulses", cap.size(), 80);
        checkInit("merged init");
        checkRefresh("merged refresh");
        sz = cap.size();
        repeat (100) @(negedge CLK);
        checkOutput("no second refresh", cap.size(), sz);
        checkOutput("busy stays low", lcd_busy, 0);

        // Random writes checked against the shadow model.
        for (int i = 0; i < 20; i++)
            applyStimulus(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          8'($urandom_range(0, 255)), 1'b0);
        cap.delete();
        applyStimulus(1'b0, 1'b0, 4'h0, 8'h00, 1'b1);
        waitQuiet("random refresh", 2000);
        checkRefresh("random refresh");

        // Writes every cycle during a refresh are all retained.
        cap.delete();
        tick();
        update = 1'b1; lcd_we = 1'b1; lcd_row = 1'b1; lcd_col = 4'd15; lcd_char = 8'h5A;
        model[31] = 8'h5A;
        tick();
        update = 1'b0;
        n = 0;
        while (n < 2000) begin
            @(negedge CLK);
            if (!lcd_busy) break;
            n++;
        end
        #2 lcd_we = 1'b0;
        checkOutput("refresh under writes ends", (n < 2000) ? 1 : 0, 1);
        waitQuiet("write refresh", 2000);
        checkRefresh("write refresh");
        cap.delete();
        applyStimulus(1'b0, 1'b0, 4'h0, 8'h00, 1'b1);
        waitQuiet("after-write refresh", 2000);
        checkRefresh("after-write refresh");

        // Reset in the middle of a refresh while E is high.
        applyStimulus(1'b0, 1'b0, 4'h0, 8'h00, 1'b1);
        repeat (100) @(negedge CLK);
        n = 0;
        while (!(LCD_E && LCD_DB != 4'h0) && n < 200) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("found E high mid-refresh", (n < 200) ? 1 : 0, 1);
        #2 RST = 1'b0;
        #1;
        checkOutput("mid reset E", LCD_E, 0);
        checkOutput("mid reset RS", LCD_RS, 0);
        checkOutput("mid reset DB", LCD_DB, 0);
        checkOutput("mid reset busy", lcd_busy, 1);
        resetModel();
        repeat (3) tick();
        cap.delete();
        RST = 1'b1;
        waitQuiet("re-init", 2000);
        checkOutput("re-init pulse count", cap.size(), 12);
        checkInit("re-init");
        cap.delete();
        applyStimulus(1'b0, 1'b0, 4'h0, 8'h00, 1'b1);
        waitQuiet("cleared refresh", 2000);
        checkRefresh("cleared refresh");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
